// File: rtl/cpu_pkg.sv
// Shared CPU definitions: NOP encoding, default fetch addresses and the fetch FSM states.
package cpu_pkg;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_HALT_PC  = 32'h0000_0400;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush, hold and load controls.
// Control priority is reset > flush > hold > load; with no control asserted, the contents are kept.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        flush,
  input  logic        hold,
  input  logic [31:0] pc_d,
  input  logic [31:0] inst_d,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      valid <= 1'b0;
      pc    <= 32'h0000_0000;
      inst  <= NOP;
    end else if (hold) begin
      valid <= valid;
      pc    <= pc;
      inst  <= inst;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= pc_d;
      inst  <= inst_d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RUN/HALT fetch FSM, fetch counter and IF/ID register.
// IF_ID_valid has no ready: a slot is consumed at every edge where stall is low.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] HALT_PC  = DEFAULT_HALT_PC
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] PC_out,
  input  logic [31:0] inst_in,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        IF_ID_valid,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Inst,
  output logic        halted,
  output logic [31:0] fetch_cnt,
  output fsm_state_e  state_dbg
);

  fsm_state_e  state, state_next;
  logic [31:0] pc_q, pc_next;
  logic [31:0] cnt_q, cnt_next;
  logic        ifid_load, ifid_flush, ifid_hold;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= RUN;
      pc_q  <= RESET_PC;
      cnt_q <= 32'h0000_0000;
    end else begin
      state <= state_next;
      pc_q  <= pc_next;
      cnt_q <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    cnt_next   = cnt_q;
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    ifid_hold  = 1'b0;
    if (redirect_valid) begin
      // Redirect beats stall and also leaves HALT.
      pc_next    = redirect_pc & 32'hFFFF_FFFC;
      ifid_flush = 1'b1;
      state_next = RUN;
    end else if (state == HALT) begin
      ifid_flush = 1'b1;
    end else if (stall) begin
      ifid_hold = 1'b1;
    end else if (pc_q == HALT_PC) begin
      // The instruction at HALT_PC is never delivered.
      state_next = HALT;
      ifid_flush = 1'b1;
    end else begin
      ifid_load = 1'b1;
      pc_next   = pc_q + 32'd4;
      cnt_next  = cnt_q + 32'd1;
    end
  end

  if_id_reg u_if_id_reg (
    .clk    (clk),
    .rstn   (rstn),
    .load   (ifid_load),
    .flush  (ifid_flush),
    .hold   (ifid_hold),
    .pc_d   (pc_q),
    .inst_d (inst_in),
    .valid  (IF_ID_valid),
    .pc     (IF_ID_PC),
    .inst   (IF_ID_Inst)
  );

  assign PC_out    = pc_q;
  assign fetch_cnt = cnt_q;
  assign halted    = (state == HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (default HALT_PC and HALT_PC=8) against a rule-level model.
module tb_if_stage;
  import cpu_pkg::*;

  localparam logic [31:0] NOP_EXP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] key = 32'hA5A5_0000;

  logic [31:0] pc_o [2];
  logic [31:0] inst_i [2];
  logic        v_o [2];
  logic [31:0] ifpc_o [2];
  logic [31:0] ifinst_o [2];
  logic        halted_o [2];
  logic [31:0] cnt_o [2];
  fsm_state_e  st_o [2];

  assign inst_i[0] = pc_o[0] ^ key;
  assign inst_i[1] = pc_o[1] ^ key;

  if_stage dut (
    .clk(clk), .rstn(rstn), .PC_out(pc_o[0]), .inst_in(inst_i[0]), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .IF_ID_valid(v_o[0]), .IF_ID_PC(ifpc_o[0]), .IF_ID_Inst(ifinst_o[0]),
    .halted(halted_o[0]), .fetch_cnt(cnt_o[0]), .state_dbg(st_o[0])
  );

  if_stage #(.HALT_PC(32'h0000_0008)) dut_w (
    .clk(clk), .rstn(rstn), .PC_out(pc_o[1]), .inst_in(inst_i[1]), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .IF_ID_valid(v_o[1]), .IF_ID_PC(ifpc_o[1]), .IF_ID_Inst(ifinst_o[1]),
    .halted(halted_o[1]), .fetch_cnt(cnt_o[1]), .state_dbg(st_o[1])
  );

  // reference model: architectural view of the fetch stage
  logic [31:0] m_halt_pc [2];
  logic [31:0] m_pc [2];
  logic        m_valid [2];
  logic [31:0] m_ifpc [2];
  logic        m_ifpc_known [2];
  logic [31:0] m_inst [2];
  logic        m_halted [2];
  logic [31:0] m_cnt [2];

  int vectors = 0;
  int miscompares = 0;

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic void model_edge(input int i);
    if (!rstn) begin
      m_pc[i] = 32'h0; m_valid[i] = 1'b0; m_ifpc[i] = 32'h0; m_ifpc_known[i] = 1'b1;
      m_inst[i] = NOP_EXP; m_halted[i] = 1'b0; m_cnt[i] = 32'h0;
    end else if (redirect_valid) begin
      m_pc[i] = {redirect_pc[31:2], 2'b00}; m_valid[i] = 1'b0; m_ifpc[i] = 32'h0;
      m_ifpc_known[i] = 1'b1; m_inst[i] = NOP_EXP; m_halted[i] = 1'b0;
    end else if (m_halted[i] || stall) begin
      // everything held; valid is already 0 while halted
    end else if (m_pc[i] == m_halt_pc[i]) begin
      m_halted[i] = 1'b1; m_valid[i] = 1'b0; m_inst[i] = NOP_EXP; m_ifpc_known[i] = 1'b0;
    end else begin
      m_ifpc[i] = m_pc[i]; m_ifpc_known[i] = 1'b1; m_inst[i] = m_pc[i] ^ key;
      m_valid[i] = 1'b1; m_pc[i] = m_pc[i] + 32'd4; m_cnt[i] = m_cnt[i] + 32'd1;
    end
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pc_out[%0d]", i), pc_o[i], m_pc[i]);
      chk($sformatf("if_id_valid[%0d]", i), {31'b0, v_o[i]}, {31'b0, m_valid[i]});
      chk($sformatf("halted[%0d]", i), {31'b0, halted_o[i]}, {31'b0, m_halted[i]});
      chk($sformatf("state_dbg[%0d]", i), {31'b0, st_o[i] == HALT}, {31'b0, m_halted[i]});
      chk($sformatf("fetch_cnt[%0d]", i), cnt_o[i], m_cnt[i]);
      if (m_valid[i] || !m_ifpc_known[i] == 1'b0)
        chk($sformatf("if_id_pc[%0d]", i), ifpc_o[i], m_ifpc[i]);
      if (m_valid[i])
        chk($sformatf("if_id_inst[%0d]", i), ifinst_o[i], m_inst[i]);
      else
        chk($sformatf("if_id_nop[%0d]", i), ifinst_o[i], NOP_EXP);
    end
  endtask

  // driver: inputs change 1 time unit after the edge, checks 1 unit after the next edge
  task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rpc);
    rstn = r; stall = s; redirect_valid = rv; redirect_pc = rpc;
    key = $urandom;
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    m_halt_pc[0] = 32'h0000_0400;
    m_halt_pc[1] = 32'h0000_0008;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'hx; m_valid[i] = 1'b0; m_ifpc[i] = 32'h0; m_ifpc_known[i] = 1'b0;
      m_inst[i] = NOP_EXP; m_halted[i] = 1'b0; m_cnt[i] = 32'h0;
    end
    @(posedge clk);
    #1;

    // reset, straight-line fetch with a 3-cycle stall at PC 8
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("pc_at_8", pc_o[0], 32'h0000_0008);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("stall_ifpc", ifpc_o[0], 32'h0000_0004);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("fetch_cnt_6", cnt_o[0], 32'd6);

    // stall and redirect together
    step(1'b1, 1'b1, 1'b1, 32'h0000_0042);
    chk("redir_pc_40", pc_o[0], 32'h0000_0040);

    // randomized traffic
    for (int k = 0; k < 300; k++) begin
      logic r, s, rv;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) != 0);
      s   = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 32'h0000_03F0 + 32'($urandom_range(0, 31))
                                        : 32'($urandom_range(0, 32'h0000_0500));
      step(r, s, rv, rpc);
    end

    // run into HALT at 0x400, sit there with stall toggling, then redirect out
    step(1'b1, 1'b0, 1'b1, 32'h0000_03F0);
    for (int k = 0; k < 64 && !m_halted[0]; k++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt_reached", {31'b0, halted_o[0]}, 32'd1);
    chk("halt_pc", pc_o[0], 32'h0000_0400);
    for (int k = 0; k < 10; k++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0020);
    chk("unhalt_pc", pc_o[0], 32'h0000_0020);

    // redirect to HALT_PC, halt, then reset while halted with stall and redirect asserted
    step(1'b1, 1'b0, 1'b1, 32'h0000_0400);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("halt_after_redir", {31'b0, halted_o[0]}, 32'd1);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
    chk("rst_in_halt_pc", pc_o[0], 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // PC wrap on the HALT_PC=8 instance and on the default one
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("wrap_pre", pc_o[1], 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_post", pc_o[1], 32'h0);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 The module SHALL have parameter HALT_PC, default 32'h0000_0400, meaning the fetch address at which fetching stops.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-005 The module SHALL have port PC_out, output, 32, the fetch address to the instruction memory.
REQ-006 The module SHALL have port inst_in, input, 32, the instruction at PC_out, valid combinationally in the same cycle.
REQ-007 The module SHALL have port stall, input, 1, the hazard-unit hold request.
REQ-008 The module SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 32), the branch/jump redirect resolved in EX.
REQ-009 The module SHALL have ports IF_ID_valid (output, 1), IF_ID_PC (output, 32) and IF_ID_Inst (output, 32), the IF/ID pipeline register.
REQ-010 The module SHALL have ports halted (output, 1), high in HALT, and fetch_cnt (output, 32), the count of instructions delivered to IF/ID.

Function
REQ-011 The FSM SHALL have exactly two states, RUN and HALT.
REQ-012 Event priority each cycle SHALL be: reset > redirect_valid > stall > HALT_PC detection > normal fetch.
REQ-013 Normal fetch (RUN, no redirect, no stall, PC_out != HALT_PC) SHALL take effect at the next edge:
- IF_ID_PC <= PC_out; IF_ID_Inst <= inst_in; IF_ID_valid <= 1.
- PC_out <= PC_out + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- fetch_cnt increments by 1 and wraps at 2^32.
REQ-014 Stall (no redirect) SHALL hold PC_out, all IF_ID_* outputs and fetch_cnt unchanged.
REQ-015 Redirect SHALL, at the next edge, load PC_out <= {redirect_pc[31:2],2'b00}, IF_ID_valid <= 0, IF_ID_Inst <= 32'h0000_0013 (NOP) and IF_ID_PC <= 0; fetch_cnt is unchanged and the state becomes RUN.
REQ-016 Redirect SHALL win over a simultaneous stall; the stalled IF/ID content is discarded.
REQ-017 In RUN with PC_out == HALT_PC, no redirect and no stall, the next edge SHALL:
- enter HALT and hold PC_out;
- set IF_ID_valid <= 0 and IF_ID_Inst <= NOP;
- not deliver the instruction at HALT_PC.
REQ-018 In HALT, PC_out and fetch_cnt SHALL be held, IF_ID_valid SHALL stay 0, halted SHALL be 1, and stall SHALL be ignored.
REQ-019 A redirect in HALT SHALL return the FSM to RUN per REQ-015, cancelling a speculative halt.
REQ-020 A redirect to HALT_PC SHALL load PC_out = HALT_PC, and the following non-stalled cycle SHALL enter HALT.
REQ-021 PC_out SHALL be driven directly from the PC register, with no combinational path from inputs.

Reset
REQ-022 While rstn is sampled low at an edge, the next state SHALL be: PC_out = RESET_PC, IF_ID_valid = 0, IF_ID_PC = 0, IF_ID_Inst = NOP, halted = 0, fetch_cnt = 0, FSM = RUN.
REQ-023 Reset asserted mid-operation, including in HALT, during stall or with a simultaneous redirect, SHALL override all other inputs.
REQ-024 The first edge with rstn high SHALL perform a normal fetch of RESET_PC if stall and redirect_valid are both low.

Structure
REQ-025 The shared package cpu_pkg SHALL hold the NOP constant (32'h0000_0013), the default RESET_PC and HALT_PC, and the two-state FSM enum.
REQ-026 The IF/ID register SHALL be a sub-module, if_id_reg, with load, flush and hold controls; the PC, FSM and counter SHALL live in if_stage.

Verification
REQ-027 Straight-line fetch: reset, then 5 cycles, stall=0, inst_in=PC^32'hA5A5_0000 -> PC_out sequence 0,4,8,C,10,14; IF_ID_PC lags PC_out by one cycle; fetch_cnt=5.
REQ-028 Stall: stall=1 for 3 cycles at PC_out=8 -> PC_out=8, IF_ID_PC=4 and fetch_cnt constant for those cycles; resumes at C.
REQ-029 Stall+redirect: stall=1 and redirect_valid=1 with redirect_pc=32'h0000_0042 in the same cycle -> PC_out=40, IF_ID_valid=0, IF_ID_Inst=00000013 next cycle.
REQ-030 Halt: run to PC_out=400 -> halted=1 next cycle, PC_out stays 400 and IF_ID_valid=0 for 10 cycles; then redirect_pc=20 -> halted=0, PC_out=20.
REQ-031 Reset in HALT: rstn=0 for one edge -> PC_out=0, halted=0, fetch_cnt=0, IF_ID_valid=0.
REQ-032 Wrap: redirect to FFFF_FFFC with HALT_PC overridden to 8 -> PC_out goes FFFF_FFFC then 0; fetch_cnt +1.
